// File: rtl/adc_capture_avg.sv
// adc_capture_avg
//   Captures NUM_CH parallel ADC channels. It averages each channel over
//   windows of 2^LOG2_AVG accepted samples and reports the window peak-to-peak
//   span (max - min) for each channel.
//
// Ports
//   CLOCK      : sample clock. All logic runs on the rising edge.
//   RESET      : synchronous, active-high reset.
//   ADC_DATA   : NUM_CH samples. Channel k is at [k*DATA_W +: DATA_W].
//   ADC_VALID  : ADC_DATA carries a new sample this cycle.
//   ENABLE     : capture enable. Dropping it discards the partial window.
//   OUT_READY  : consumer accepts the current result.
//   OVR_CLR    : clears OVERRUN.
//   OUT_DATA   : per-channel window average, packed like ADC_DATA.
//   OUT_PEAK   : per-channel window max - min, unsigned, packed like ADC_DATA.
//   OUT_VALID  : OUT_DATA and OUT_PEAK hold an unconsumed result.
//   OVERRUN    : sticky. Set when a new result overwrote an unconsumed one.
//   state_dbg  : current FSM state (0 = IDLE, 1 = ACCUM).
//
// SIGNED_OUT = 0 : offset-binary samples in, unsigned averages out.
// SIGNED_OUT = 1 : the sample MSB is inverted, so the data is treated as
//                  two's complement. Sum, compare and shift are all signed.
module adc_capture_avg #(
  parameter int DATA_W     = 12,
  parameter int NUM_CH     = 2,
  parameter int LOG2_AVG   = 4,
  parameter int SIGNED_OUT = 0
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic [NUM_CH*DATA_W-1:0] ADC_DATA,
  input  logic                     ADC_VALID,
  input  logic                     ENABLE,
  input  logic                     OUT_READY,
  input  logic                     OVR_CLR,
  output logic [NUM_CH*DATA_W-1:0] OUT_DATA,
  output logic [NUM_CH*DATA_W-1:0] OUT_PEAK,
  output logic                     OUT_VALID,
  output logic                     OVERRUN,
  output logic                     state_dbg
);

  localparam int ACC_W = DATA_W + LOG2_AVG;
  localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam logic [DATA_W-1:0] MSB_MASK = DATA_W'(1) << (DATA_W - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t state, state_next;
  logic   accept;
  logic   clear;

  always_ff @(posedge CLOCK) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  // Acceptance depends only on ENABLE and ADC_VALID. A sample that arrives
  // on the same cycle ENABLE rises therefore already counts. Window state is
  // cleared on every cycle that ends in IDLE.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    clear      = 1'b0;
    case (state)
      IDLE:    if (ENABLE)  state_next = ACCUM;
      ACCUM:   if (!ENABLE) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    accept = ENABLE && ADC_VALID;
    clear  = (state_next == IDLE);
  end

  assign state_dbg = (state == ACCUM);

  // Sample counter. With LOG2_AVG = 0, every sample is both first and last.
  logic [CNT_W-1:0] cnt;
  logic             first;
  logic             last;
  logic             complete;

  assign first    = (LOG2_AVG == 0) || (cnt == '0);
  assign last     = (LOG2_AVG == 0) || (cnt == {CNT_W{1'b1}});
  assign complete = accept && last;

  always_ff @(posedge CLOCK) begin
    if (RESET || clear) cnt <= '0;
    else if (accept)    cnt <= cnt + CNT_W'(1);
  end

  // Per-channel datapath. The window result is taken from the *_next values.
  // The result that loads on the completing edge therefore already includes
  // the last sample.
  logic [NUM_CH*DATA_W-1:0] avg_all;
  logic [NUM_CH*DATA_W-1:0] peak_all;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [DATA_W-1:0]        raw;
    logic [DATA_W-1:0]        s;
    logic signed [DATA_W:0]   sx;
    logic [ACC_W-1:0]         s_ext;
    logic [ACC_W-1:0]         acc;
    logic [ACC_W-1:0]         acc_next;
    logic signed [DATA_W:0]   mn;
    logic signed [DATA_W:0]   mx;
    logic signed [DATA_W:0]   mn_next;
    logic signed [DATA_W:0]   mx_next;
    logic [DATA_W-1:0]        span;

    assign raw = ADC_DATA[k*DATA_W +: DATA_W];

    // sx is a one-bit-wider signed value. For unsigned mode it is
    // zero-extended, so one signed compare serves both modes.
    always_comb begin
      s        = (SIGNED_OUT != 0) ? (raw ^ MSB_MASK) : raw;
      sx       = (SIGNED_OUT != 0) ? $signed({s[DATA_W-1], s}) : $signed({1'b0, s});
      s_ext    = ACC_W'(sx);
      acc_next = first ? s_ext : (acc + s_ext);
      mn_next  = (first || (sx < mn)) ? sx : mn;
      mx_next  = (first || (sx > mx)) ? sx : mx;
      span     = DATA_W'(mx_next - mn_next);
    end

    always_ff @(posedge CLOCK) begin
      if (RESET || clear) begin
        acc <= '0;
        mn  <= '0;
        mx  <= '0;
      end else if (accept) begin
        acc <= acc_next;
        mn  <= mn_next;
        mx  <= mx_next;
      end
    end

    if (SIGNED_OUT != 0) begin : g_signed
      assign avg_all[k*DATA_W +: DATA_W] = DATA_W'($signed(acc_next) >>> LOG2_AVG);
    end else begin : g_unsigned
      assign avg_all[k*DATA_W +: DATA_W] = DATA_W'(acc_next >> LOG2_AVG);
    end
    assign peak_all[k*DATA_W +: DATA_W] = span;
  end

  // Output handshake: a result transfers on any cycle with OUT_VALID = 1 and
  // OUT_READY = 1. OUT_VALID never drops without a transfer. A completing
  // window always loads: it replaces an unconsumed result and sets OVERRUN,
  // unless that result is being consumed on the same cycle.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      OUT_DATA  <= '0;
      OUT_PEAK  <= '0;
      OUT_VALID <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      if (complete) begin
        OUT_DATA  <= avg_all;
        OUT_PEAK  <= peak_all;
        OUT_VALID <= 1'b1;
      end else if (OUT_VALID && OUT_READY) begin
        OUT_VALID <= 1'b0;
      end
      if (complete && OUT_VALID && !OUT_READY) OVERRUN <= 1'b1;
      else if (OVR_CLR)                        OVERRUN <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_capture_avg.sv
module tb_adc_capture_avg;
  localparam int DW    = 12;
  localparam int NC    = 2;
  localparam int W     = DW * NC;
  localparam int N_DUT = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, en, vld, rdy, clr;
  logic [W-1:0] din;

  logic [W-1:0] o_data  [N_DUT];
  logic [W-1:0] o_peak  [N_DUT];
  logic         o_valid [N_DUT];
  logic         o_ovr   [N_DUT];
  logic         o_st    [N_DUT];

  int checks = 0;
  int errors = 0;

  // DUT 0: unsigned, 4-sample window; DUT 1: signed, 4-sample; DUT 2: unsigned, 1-sample
  int lg [N_DUT] = '{2, 2, 0};
  bit sg [N_DUT] = '{1'b0, 1'b1, 1'b0};

  adc_capture_avg #(.DATA_W(DW), .NUM_CH(NC), .LOG2_AVG(2), .SIGNED_OUT(0)) u_u2 (
    .CLOCK(clk), .RESET(rst), .ADC_DATA(din), .ADC_VALID(vld), .ENABLE(en),
    .OUT_READY(rdy), .OVR_CLR(clr), .OUT_DATA(o_data[0]), .OUT_PEAK(o_peak[0]),
    .OUT_VALID(o_valid[0]), .OVERRUN(o_ovr[0]), .state_dbg(o_st[0]));

  adc_capture_avg #(.DATA_W(DW), .NUM_CH(NC), .LOG2_AVG(2), .SIGNED_OUT(1)) u_s2 (
    .CLOCK(clk), .RESET(rst), .ADC_DATA(din), .ADC_VALID(vld), .ENABLE(en),
    .OUT_READY(rdy), .OVR_CLR(clr), .OUT_DATA(o_data[1]), .OUT_PEAK(o_peak[1]),
    .OUT_VALID(o_valid[1]), .OVERRUN(o_ovr[1]), .state_dbg(o_st[1]));

  adc_capture_avg #(.DATA_W(DW), .NUM_CH(NC), .LOG2_AVG(0), .SIGNED_OUT(0)) u_u0 (
    .CLOCK(clk), .RESET(rst), .ADC_DATA(din), .ADC_VALID(vld), .ENABLE(en),
    .OUT_READY(rdy), .OVR_CLR(clr), .OUT_DATA(o_data[2]), .OUT_PEAK(o_peak[2]),
    .OUT_VALID(o_valid[2]), .OVERRUN(o_ovr[2]), .state_dbg(o_st[2]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int           m_cnt   [N_DUT];
  int           m_win   [N_DUT][NC][256];
  logic [W-1:0] m_data  [N_DUT];
  logic [W-1:0] m_peak  [N_DUT];
  bit           m_valid [N_DUT];
  bit           m_ovr   [N_DUT];
  bit           m_st    [N_DUT];

  // Offset-binary code to numeric value.
  function automatic int to_val(input int d, input logic [DW-1:0] raw);
    return sg[d] ? (int'(raw) - (1 << (DW - 1))) : int'(raw);
  endfunction

  task automatic model_step();
    bit           done;
    logic [W-1:0] nd, np;
    int           n, sum, mx, mn, avg, v;
    for (int d = 0; d < N_DUT; d++) begin
      if (rst) begin
        m_cnt[d] = 0; m_data[d] = '0; m_peak[d] = '0;
        m_valid[d] = 0; m_ovr[d] = 0; m_st[d] = 0;
      end else begin
        done = 0; nd = '0; np = '0;
        n = 1 << lg[d];
        if (en && vld) begin
          for (int c = 0; c < NC; c++) m_win[d][c][m_cnt[d]] = to_val(d, din[c*DW +: DW]);
          m_cnt[d]++;
          if (m_cnt[d] == n) begin
            done = 1;
            for (int c = 0; c < NC; c++) begin
              sum = 0; mx = m_win[d][c][0]; mn = mx;
              for (int i = 0; i < n; i++) begin
                v = m_win[d][c][i];
                sum += v;
                if (v > mx) mx = v;
                if (v < mn) mn = v;
              end
              avg = sum / n;
              if (sum < 0 && (sum % n) != 0) avg = avg - 1;  // floor, not toward zero
              nd[c*DW +: DW] = DW'(avg);
              np[c*DW +: DW] = DW'(mx - mn);
            end
            m_cnt[d] = 0;
          end
        end
        if (!en) m_cnt[d] = 0;
        if (done && m_valid[d] && !rdy) m_ovr[d] = 1;
        else if (clr)                   m_ovr[d] = 0;
        if (done) begin
          m_data[d] = nd; m_peak[d] = np; m_valid[d] = 1;
        end else if (m_valid[d] && rdy) begin
          m_valid[d] = 0;
        end
        m_st[d] = en;
      end
    end
  endtask

  // ---------------- scoreboard: every cycle ----------------
  always @(posedge clk) begin
    model_step();
    #1;
    for (int d = 0; d < N_DUT; d++) begin
      check($sformatf("d%0d valid", d), 64'(o_valid[d]), 64'(m_valid[d]));
      check($sformatf("d%0d overrun", d), 64'(o_ovr[d]), 64'(m_ovr[d]));
      check($sformatf("d%0d data", d), 64'(o_data[d]), 64'(m_data[d]));
      check($sformatf("d%0d peak", d), 64'(o_peak[d]), 64'(m_peak[d]));
      check($sformatf("d%0d state", d), 64'(o_st[d]), 64'(m_st[d]));
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input bit e, input bit v, input logic [DW-1:0] c0,
                     input logic [DW-1:0] c1, input bit r, input bit cl);
    rst = 0; en = e; vld = v; din = {c1, c0}; rdy = r; clr = cl;
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    en = 1'($urandom); vld = 1'($urandom); rdy = 1'($urandom); clr = 1'($urandom);
    din = W'($urandom);
  endtask

  // Literal check against both the DUT and the model.
  task automatic pin(input string name, input int d, input logic [W-1:0] act,
                     input logic [W-1:0] mdl, input logic [W-1:0] exp);
    check($sformatf("%s d%0d", name, d), 64'(act), 64'(exp));
    check($sformatf("%s model d%0d", name, d), 64'(mdl), 64'(exp));
  endtask

  initial begin
    rst = 1; rand_inputs();
    @(negedge clk);
    rand_inputs();
    @(negedge clk);
    for (int d = 0; d < N_DUT; d++) begin
      check($sformatf("reset data d%0d", d), 64'(o_data[d]), 64'd0);
      check($sformatf("reset peak d%0d", d), 64'(o_peak[d]), 64'd0);
      check($sformatf("reset valid d%0d", d), 64'(o_valid[d]), 64'd0);
      check($sformatf("reset ovr d%0d", d), 64'(o_ovr[d]), 64'd0);
    end

    // Basic window
    cyc(1, 1, 100, 0, 0, 0);
    cyc(1, 1, 100, 4, 0, 0);
    cyc(1, 1, 100, 8, 0, 0);
    check("basic valid before 4th", 64'(o_valid[0]), 64'd0);
    cyc(1, 1, 100, 12, 0, 0);
    check("basic valid after 4th", 64'(o_valid[0]), 64'd1);
    pin("basic data", 0, o_data[0], m_data[0], 24'h006064);
    pin("basic peak", 0, o_peak[0], m_peak[0], 24'h00C000);
    cyc(0, 0, 0, 0, 1, 0);
    check("basic consumed", 64'(o_valid[0]), 64'd0);

    // Backpressure / overrun
    cyc(0, 0, 0, 0, 0, 1);
    check("ovr cleared pre", 64'(o_ovr[0]), 64'd0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 10, 0, 0, 0);
    check("bp first ovr", 64'(o_ovr[0]), 64'd0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 20, 0, 0, 0);
    pin("bp data", 0, o_data[0], m_data[0], 24'h000014);
    check("bp overrun set", 64'(o_ovr[0]), 64'd1);
    check("bp valid", 64'(o_valid[0]), 64'd1);
    cyc(1, 0, 0, 0, 0, 1);
    check("bp overrun cleared", 64'(o_ovr[0]), 64'd0);
    cyc(0, 0, 0, 0, 1, 0);

    // Abort partial window
    cyc(1, 1, 12'hFFF, 12'hFFF, 0, 0);
    cyc(1, 1, 12'hFFF, 12'hFFF, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 8, 8, 0, 0);
    pin("abort data", 0, o_data[0], m_data[0], 24'h008008);
    pin("abort peak", 0, o_peak[0], m_peak[0], 24'h000000);
    cyc(0, 0, 0, 0, 1, 0);

    // Continuous vs gapped stream, same samples
    cyc(1, 1, 1, 0, 0, 0); cyc(1, 1, 2, 4, 0, 0); cyc(1, 1, 3, 8, 0, 0); cyc(1, 1, 6, 12, 0, 0);
    pin("cont data", 0, o_data[0], m_data[0], 24'h006003);
    pin("cont peak", 0, o_peak[0], m_peak[0], 24'h00C005);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 1, 1, 0, 0, 0);   cyc(1, 0, 12'h7A5, 12'h3C3, 0, 0);
    cyc(1, 1, 2, 4, 0, 0);   cyc(1, 0, 12'hFFF, 12'h000, 0, 0);
    cyc(1, 1, 3, 8, 0, 0);   cyc(1, 0, 12'h123, 12'hABC, 0, 0);
    cyc(1, 1, 6, 12, 0, 0);
    pin("gap data", 0, o_data[0], m_data[0], 24'h006003);
    pin("gap peak", 0, o_peak[0], m_peak[0], 24'h00C005);

    // Completion coinciding with handshake: no overrun
    cyc(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 1, 40, 40, 0, 0);
    cyc(1, 1, 40, 40, 1, 0);
    check("simul valid", 64'(o_valid[0]), 64'd1);
    check("simul ovr", 64'(o_ovr[0]), 64'd0);
    pin("simul data", 0, o_data[0], m_data[0], 24'h028028);
    cyc(0, 0, 0, 0, 1, 0);

    // Signed variant
    for (int i = 0; i < 4; i++) cyc(1, 1, 12'h800, 12'h800, 0, 0);
    pin("signed zero", 1, o_data[1], m_data[1], 24'h000000);
    for (int i = 0; i < 4; i++) cyc(1, 1, 12'h000, 12'h000, 0, 0);
    pin("signed min", 1, o_data[1], m_data[1], 24'h800800);
    for (int i = 0; i < 2; i++) begin
      cyc(1, 1, 12'hFFF, 12'hFFF, 0, 0);
      cyc(1, 1, 12'h000, 12'h000, 0, 0);
    end
    pin("signed mix data", 1, o_data[1], m_data[1], 24'hFFFFFF);
    pin("signed mix peak", 1, o_peak[1], m_peak[1], 24'hFFFFFF);

    // Single-sample window
    cyc(1, 1, 12'h07B, 12'h1C8, 1, 0);
    pin("l0 data", 2, o_data[2], m_data[2], 24'h1C807B);
    pin("l0 peak", 2, o_peak[2], m_peak[2], 24'h000000);
    cyc(0, 0, 0, 0, 1, 1);

    // Reset mid-window: next window starts fresh
    cyc(1, 1, 12'hFFF, 12'hFFF, 0, 0);
    cyc(1, 1, 12'hFFF, 12'hFFF, 0, 0);
    rst = 1; en = 1; vld = 1; din = W'($urandom); rdy = 0; clr = 0;
    @(negedge clk);
    check("midreset valid", 64'(o_valid[0]), 64'd0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 5, 5, 0, 0);
    pin("midreset data", 0, o_data[0], m_data[0], 24'h005005);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      en  = ($urandom_range(0, 15) != 0);
      vld = ($urandom_range(0, 2) != 0);
      rdy = 1'($urandom);
      clr = ($urandom_range(0, 15) == 0);
      for (int c = 0; c < NC; c++) din[c*DW +: DW] = DW'($urandom_range(0, 4095));
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
